fifo_read_port: RTL and testbench
=================================

Name: fifo_read_port

Overview:
- Read-side controller for the team's single-clock RAM-based FIFOs; the counterpart of the write-side pointer logic.
- Takes the writer's wrap-bit write pointer and owns the read pointer, which uses the same encoding.
- Prefetches words from a 1-cycle-latency RAM into a 2-entry output buffer and presents them on a valid/ready stream.
- Returns the read pointer to the writer for full detection; sits between FIFO storage and downstream consumers such as line buffers and conv engines.

Parameters:
- DATA_WIDTH, 16, width of the stored word.
- DEPTH, 2**16, number of RAM entries; need not be a power of two.
- ADDR_WIDTH (localparam), $clog2(DEPTH), width of the RAM address.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_ptr  in  ADDR_WIDTH+1  writer pointer: {wrap bit, low}, same clock domain.
- rd_ptr  out  ADDR_WIDTH+1  read pointer, sent to the writer for full detection.
- ram_rd_en  out  1  RAM read strobe.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address, equal to rd_ptr[ADDR_WIDTH-1:0].
- ram_rd_data  in  DATA_WIDTH  RAM data, valid on the edge after ram_rd_en.
- m_data  out  DATA_WIDTH  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer ready.
- empty  out  1  no words anywhere: RAM region, in-flight read, or output buffer.
- level  out  ADDR_WIDTH+1  total word count (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, in-flight flag=0, buffer count=0, m_valid=0, m_data=0, ram_rd_en=0, empty=1, level=0.
- Pointer encoding: on each issued read, low becomes 0 if low==DEPTH-1 and the wrap bit toggles; otherwise low increments.
- ram_empty = (rd_ptr == wr_ptr).
- RAM occupancy: wr_low - rd_low when the wrap bits are equal; DEPTH - rd_low + wr_low when they differ.
- pop = m_valid & m_ready.
- Issue rule (combinational from registers, wr_ptr and m_ready):
  - ram_rd_en = !ram_empty & (buf_cnt + inflight - pop < 2).
  - rd_ptr advances on the edge where ram_rd_en=1.
- Return path: the in-flight flag is set on the issue edge. On the next edge ram_rd_data is written into the buffer tail, buf_cnt increments, and the in-flight flag clears unless a new read issued in the same cycle.
- Buffer: 2-entry FIFO; m_data/m_valid reflect the head entry. A simultaneous capture and pop keeps buf_cnt unchanged with order preserved. The buffer never overflows by construction; the bench asserts this.
- Latency: wr_ptr becomes != rd_ptr after edge E0, so ram_rd_en=1 during the following cycle. The word is captured at E2 and m_valid=1 after E2.
- Throughput: with m_ready held 1, one word per cycle is sustained.
- Hold rule: while m_valid=1 and m_ready=0, m_data is held stable.
- empty = ram_empty & !inflight & (buf_cnt==0).
- level = RAM occupancy + inflight + buf_cnt, registered; maximum DEPTH+2 is clamped to DEPTH for reporting.
- Full condition: wr_ptr = {~rd_msb, rd_low} means RAM occupancy is DEPTH; reads issue normally.
- wr_ptr equal to rd_ptr with the wrap bit differing is treated as full, never as empty.
- Reset mid-operation: a pending in-flight RAM word is discarded, and no capture occurs on the first edge after release.

Optional Feature:
- Macro: FIFO_READ_PORT_LEVEL_EN.
- Defined: level is computed and registered as above, updating the edge after any pointer or buffer change.
- Undefined: the occupancy arithmetic is not built and level is tied to 0; the port remains present.

Decomposition:
- Shared package fifo_pkg:
  - pointer-width constant function (clog2+1);
  - pointer-increment function with the wrap at DEPTH-1;
  - occupancy function (wrap-bit compare plus subtraction);
  - output buffer depth constant OUT_BUF_DEPTH=2.
- One sub-module: fifo_out_skid, the 2-entry buffer with capture/pop, count, head data and valid.

Test Plan:
- Reset, wr_ptr=0, m_ready=1 for 10 cycles -> ram_rd_en=0, m_valid=0, empty=1, level=0, rd_ptr=0.
- DEPTH=8, wr_ptr 0->3, m_ready=1 -> ram_rd_addr 0,1,2 in 3 consecutive cycles; m_valid high 3 cycles starting 2 edges after wr_ptr change, data D0,D1,D2; final rd_ptr=3, empty=1.
- wr_ptr=8 (full, {1,000}), m_ready=0 -> exactly 2 reads issued then ram_rd_en=0; m_data=D0 held; level=8. Then m_ready=1 -> D0..D7 in order, no drop or duplicate.
- DEPTH=5 (non-power-of-two), stream 12 words with random m_ready -> rd_ptr low sequence 0..4,0..4,0,1 with wrap bit toggling at each 4->0; data order intact.
- Simultaneous capture and pop with m_ready toggling every cycle -> buf_cnt never exceeds 2, order intact.
- rst pulsed while inflight=1 and buf_cnt=1 -> all outputs at reset values immediately; no word emitted from the discarded read.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer/occupancy helpers for the single-clock RAM FIFOs
package fifo_pkg;

    // Entries in the read-side output buffer
    localparam int OUT_BUF_DEPTH = 2;

    // Wrap-bit pointer width: address bits plus one wrap bit
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Advance a {wrap, low} pointer; low wraps at depth-1 and toggles the wrap bit
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int aw, input int depth);
        logic [31:0] low;
        logic        wrap;
        low  = ptr & ((32'd1 << aw) - 32'd1);
        wrap = ptr[aw];
        if (low == 32'(depth - 1)) begin
            return 32'(~wrap) << aw;
        end
        return (32'(wrap) << aw) | (low + 32'd1);
    endfunction

    // Words between rd and wr; equal lows with differing wrap bits means full
    function automatic logic [31:0] occupancy(input logic [31:0] wr, input logic [31:0] rd,
                                              input int aw, input int depth);
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        if (wr[aw] == rd[aw]) begin
            return (wr & mask) - (rd & mask);
        end
        return 32'(depth) - (rd & mask) + (wr & mask);
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// rtl/fifo_out_skid.sv - 2-entry output buffer presenting the head word on a valid/ready stream
module fifo_out_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] capture_data,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;

    assign valid = (count != 2'd0);
    assign data  = head;
    assign pop   = valid & ready;

    // Head/tail shift buffer: pops promote the tail, captures fill the first free slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= capture_data;
                    end else begin
                        tail <= capture_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= capture_data;
                    end else begin
                        head <= tail;
                        tail <= capture_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_read_port.sv
// rtl/fifo_read_port.sv - FIFO read-side controller; FIFO_READ_PORT_LEVEL_EN enables the level output
module fifo_read_port
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 2**16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int PTR_W      = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_W-1:0]      wr_ptr,
    output logic [PTR_W-1:0]      rd_ptr,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  empty,
    output logic [PTR_W-1:0]      level
);

    logic       inflight;
    logic [1:0] buf_cnt;
    logic       ram_empty;
    logic       pop;
    logic [2:0] pending;
    logic       issue;

    // A differing wrap bit with equal lows is full, so only exact equality is empty
    assign ram_empty   = (rd_ptr == wr_ptr);
    assign pop         = m_valid & m_ready;
    assign pending     = {2'b00, inflight} + {1'b0, buf_cnt};
    // Issue only if the word will have a buffer slot when it returns (pop frees one)
    assign issue       = !ram_empty && (pending < (3'(OUT_BUF_DEPTH) + {2'b00, pop}));
    assign ram_rd_en   = issue & ~rst;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign empty       = ram_empty & ~inflight & (buf_cnt == 2'd0);

    // Advance the read pointer on each issue and remember that a RAM word is on its way
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (ram_rd_en) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), ADDR_WIDTH, DEPTH));
            end
            inflight <= ram_rd_en;
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .capture     (inflight),
        .capture_data(ram_rd_data),
        .ready       (m_ready),
        .data        (m_data),
        .valid       (m_valid),
        .count       (buf_cnt)
    );

`ifdef FIFO_READ_PORT_LEVEL_EN
    logic [31:0] total;

    assign total = occupancy(32'(wr_ptr), 32'(rd_ptr), ADDR_WIDTH, DEPTH)
                 + 32'(inflight) + 32'(buf_cnt);

    // Registered word count; RAM, in-flight and buffer can exceed DEPTH by two, reported as DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= (total > 32'(DEPTH)) ? PTR_W'(DEPTH) : PTR_W'(total);
        end
    end
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_fifo_read_port.sv
// tb/tb_fifo_read_port.sv - randomized self-checking bench for fifo_read_port (DEPTH 8 and 5)
module tb_fifo_read_port;

    logic clk;
    logic rst;

    logic [3:0]  a_wr_ptr, a_rd_ptr, a_level;
    logic        a_rd_en, a_valid, a_ready, a_empty;
    logic [2:0]  a_addr;
    logic [15:0] a_rdata, a_data;
    logic [15:0] mem_a [0:7];

    logic [3:0]  b_wr_ptr, b_rd_ptr, b_level;
    logic        b_rd_en, b_valid, b_ready, b_empty;
    logic [2:0]  b_addr;
    logic [15:0] b_rdata, b_data;
    logic [15:0] mem_b [0:4];

    int n_cmp;
    int n_bad;

    fifo_read_port #(.DATA_WIDTH(16), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .wr_ptr(a_wr_ptr), .rd_ptr(a_rd_ptr),
        .ram_rd_en(a_rd_en), .ram_rd_addr(a_addr), .ram_rd_data(a_rdata),
        .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready),
        .empty(a_empty), .level(a_level)
    );

    fifo_read_port #(.DATA_WIDTH(16), .DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .wr_ptr(b_wr_ptr), .rd_ptr(b_rd_ptr),
        .ram_rd_en(b_rd_en), .ram_rd_addr(b_addr), .ram_rd_data(b_rdata),
        .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready),
        .empty(b_empty), .level(b_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= mem_a[a_addr];
        if (b_rd_en) b_rdata <= mem_b[b_addr];
    end

    function automatic logic [3:0] ptr_of(input int n, input int depth);
        return 4'(((n / depth) % 2) * 8 + (n % depth));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        a_wr_ptr = '0;
        b_wr_ptr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_wr_ptr = '0;
        a_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (a_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got=%b want=0", a_rd_en); end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", a_valid); end
        n_cmp++; if (a_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b want=1", a_empty); end
        n_cmp++; if (a_level !== 4'd0) begin n_bad++; $display("FAIL reset_level got=%0d want=0", a_level); end
        n_cmp++; if (a_rd_ptr !== 4'd0) begin n_bad++; $display("FAIL reset_rd_ptr got=%0d want=0", a_rd_ptr); end
        n_cmp++; if (a_data !== 16'd0) begin n_bad++; $display("FAIL reset_data got=%h want=0", a_data); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_rd_en !== 1'b0 || a_valid !== 1'b0 || a_empty !== 1'b1)
            begin n_bad++; $display("FAIL idle_after_reset got=%b%b%b want=001", a_rd_en, a_valid, a_empty); end
    endtask

    task automatic test_basic();
        logic [15:0] d [0:7];
        do_reset();
        for (int i = 0; i < 8; i++) begin d[i] = 16'($urandom); mem_a[i] = d[i]; end
        a_ready = 1'b1;
        @(posedge clk);
        #1 a_wr_ptr = 4'd3;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++; if (a_rd_en !== (c < 3)) begin n_bad++; $display("FAIL basic_rd_en c=%0d got=%b want=%b", c, a_rd_en, c < 3); end
            if (c < 3) begin
                n_cmp++; if (a_addr !== 3'(c)) begin n_bad++; $display("FAIL basic_addr c=%0d got=%0d want=%0d", c, a_addr, c); end
            end
            n_cmp++; if (a_valid !== (c >= 2 && c <= 4)) begin n_bad++; $display("FAIL basic_valid c=%0d got=%b", c, a_valid); end
            if (c >= 2 && c <= 4) begin
                n_cmp++; if (a_data !== d[c-2]) begin n_bad++; $display("FAIL basic_data c=%0d got=%h want=%h", c, a_data, d[c-2]); end
            end
        end
        n_cmp++; if (a_rd_ptr !== 4'd3) begin n_bad++; $display("FAIL basic_rd_ptr got=%0d want=3", a_rd_ptr); end
        n_cmp++; if (a_empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty got=%b want=1", a_empty); end
    endtask

    task automatic test_full();
        logic [15:0] d [0:7];
        int reads, got, cyc;
        logic [3:0] exp_level;
        do_reset();
        for (int i = 0; i < 8; i++) begin d[i] = 16'($urandom); mem_a[i] = d[i]; end
        a_ready = 1'b0;
        @(posedge clk);
        #1 a_wr_ptr = 4'b1000;
        reads = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_rd_en) reads++;
            if (a_valid) begin
                n_cmp++; if (a_data !== d[0]) begin n_bad++; $display("FAIL full_hold c=%0d got=%h want=%h", c, a_data, d[0]); end
            end
        end
        n_cmp++; if (reads !== 2) begin n_bad++; $display("FAIL full_reads got=%0d want=2", reads); end
        n_cmp++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid got=%b want=1", a_valid); end
`ifdef FIFO_READ_PORT_LEVEL_EN
        exp_level = 4'd8;
`else
        exp_level = 4'd0;
`endif
        n_cmp++; if (a_level !== exp_level) begin n_bad++; $display("FAIL full_level got=%0d want=%0d", a_level, exp_level); end
        @(posedge clk);
        #1 a_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (a_valid) begin
                if (got < 8) begin
                    n_cmp++; if (a_data !== d[got]) begin n_bad++; $display("FAIL full_drain idx=%0d got=%h want=%h", got, a_data, d[got]); end
                end else begin
                    n_cmp++; n_bad++; $display("FAIL full_extra_word got=%h want=none", a_data);
                end
                got++;
            end
            cyc++;
        end
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL full_count got=%0d want=8", got); end
        n_cmp++; if (a_rd_ptr !== 4'b1000) begin n_bad++; $display("FAIL full_rd_ptr got=%b want=1000", a_rd_ptr); end
        n_cmp++; if (a_empty !== 1'b1) begin n_bad++; $display("FAIL full_empty got=%b want=1", a_empty); end
    endtask

    task automatic stream_b(input int n_words, input int toggle);
        int written, popped, issued, cyc;
        logic [15:0] expq [$];
        logic [15:0] v;
        do_reset();
        expq.delete();
        written = 0; popped = 0; issued = 0; cyc = 0;
        b_ready = 1'b0;
        @(posedge clk);
        #1;
        while (popped < n_words && cyc < 600) begin
            if (written < n_words && (written - popped) < 5 && $urandom_range(0, 3) != 0) begin
                v = 16'($urandom);
                mem_b[written % 5] = v;
                expq.push_back(v);
                written++;
                b_wr_ptr = ptr_of(written, 5);
            end
            b_ready = toggle ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b_rd_en) begin
                n_cmp++; if (b_addr !== 3'(issued % 5)) begin n_bad++; $display("FAIL stream_addr n=%0d got=%0d want=%0d", issued, b_addr, issued % 5); end
                n_cmp++; if (b_rd_ptr !== ptr_of(issued, 5)) begin n_bad++; $display("FAIL stream_rd_ptr n=%0d got=%b want=%b", issued, b_rd_ptr, ptr_of(issued, 5)); end
                issued++;
            end
            if (dut_b.buf_cnt > 2'd2) begin
                n_cmp++; n_bad++; $display("FAIL buf_overflow got=%0d want<=2", dut_b.buf_cnt);
            end
            if (b_valid && b_ready) begin
                n_cmp++;
                if (popped >= written || b_data !== expq[popped]) begin
                    n_bad++; $display("FAIL stream_data idx=%0d got=%h want=%h", popped, b_data, (popped < written) ? expq[popped] : 16'hxxxx);
                end
                popped++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        n_cmp++; if (popped !== n_words) begin n_bad++; $display("FAIL stream_timeout got=%0d want=%0d", popped, n_words); end
        b_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (b_rd_ptr !== ptr_of(n_words, 5)) begin n_bad++; $display("FAIL stream_final_ptr got=%b want=%b", b_rd_ptr, ptr_of(n_words, 5)); end
        n_cmp++; if (b_empty !== 1'b1) begin n_bad++; $display("FAIL stream_empty got=%b want=1", b_empty); end
    endtask

    task automatic test_wrap();
        stream_b(12, 0);
    endtask

    task automatic test_back_to_back();
        stream_b(15, 1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) mem_a[i] = 16'($urandom) | 16'h0001;
        a_ready = 1'b0;
        @(posedge clk);
        #1 a_wr_ptr = 4'd2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (dut_a.inflight !== 1'b1 || dut_a.buf_cnt !== 2'd1)
            begin n_bad++; $display("FAIL mid_setup got=%b/%0d want=1/1", dut_a.inflight, dut_a.buf_cnt); end
        rst = 1'b1;
        a_wr_ptr = 4'd0;
        #1;
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b want=0", a_valid); end
        n_cmp++; if (a_data !== 16'd0) begin n_bad++; $display("FAIL mid_data got=%h want=0", a_data); end
        n_cmp++; if (a_rd_en !== 1'b0) begin n_bad++; $display("FAIL mid_rd_en got=%b want=0", a_rd_en); end
        n_cmp++; if (a_rd_ptr !== 4'd0) begin n_bad++; $display("FAIL mid_rd_ptr got=%0d want=0", a_rd_ptr); end
        n_cmp++; if (a_empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty got=%b want=1", a_empty); end
        n_cmp++; if (a_level !== 4'd0) begin n_bad++; $display("FAIL mid_level got=%0d want=0", a_level); end
        @(posedge clk);
        #1 rst = 1'b0;
        a_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ghost c=%0d got=%b want=0", c, a_valid); end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_cmp = 0;
        n_bad = 0;
        a_wr_ptr = '0; a_ready = 1'b0; a_rdata = '0;
        b_wr_ptr = '0; b_ready = 1'b0; b_rdata = '0;
        for (int i = 0; i < 8; i++) mem_a[i] = '0;
        for (int i = 0; i < 5; i++) mem_b[i] = '0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
